bus_burst_responder: RTL and testbench

//  Bus-slave end of the DMA burst protocol: a word-addressed memory target that serves

---
 rtl/bus_burst_responder_if.sv | 31 +++
 rtl/bus_burst_responder.sv | 150 +++++++++++++++
 tb/tb_bus_burst_responder.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/bus_burst_responder_if.sv
// Bus-side burst protocol signal bundle between the DMA master and a memory responder.
// master drives busIn_* and observes busOut_*; slave is the opposite view.
// busOut_address_data is wired-OR on the shared bus, so a responder drives 0 when idle.
interface bus_burst_responder_if;
    logic        busIn_begin_transaction;
    logic [31:0] busIn_address_data;
    logic [7:0]  busIn_burst_size;
    logic        busIn_read_n_write;
    logic        busIn_data_valid;
    logic        busIn_end_transaction;
    logic        busIn_busy;
    logic [31:0] busOut_address_data;
    logic        busOut_data_valid;
    logic        busOut_end_transaction;
    logic        busOut_busy;
    logic        busOut_error;

    modport master (
        output busIn_begin_transaction, busIn_address_data, busIn_burst_size,
               busIn_read_n_write, busIn_data_valid, busIn_end_transaction, busIn_busy,
        input  busOut_address_data, busOut_data_valid, busOut_end_transaction,
               busOut_busy, busOut_error
    );

    modport slave (
        input  busIn_begin_transaction, busIn_address_data, busIn_burst_size,
               busIn_read_n_write, busIn_data_valid, busIn_end_transaction, busIn_busy,
        output busOut_address_data, busOut_data_valid, busOut_end_transaction,
               busOut_busy, busOut_error
    );
endinterface

// File: rtl/bus_burst_responder.sv
// Word-addressed memory target for DMA bursts: serves burst reads, absorbs burst writes.
// Latency: first read beat READ_LATENCY cycles after the begin edge; writes land on the accepting edge.
// Backpressure: read beats held while busIn_busy=1; busOut_busy=1 for one cycle after the final write beat.
// Ports: clock, reset (async, active high), bus (slave view of bus_burst_responder_if).
module bus_burst_responder #(
    parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000,
    parameter int          DEPTH_LOG2   = 10,
    parameter int          READ_LATENCY = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    bus_burst_responder_if.slave  bus
);
    localparam int           AW        = DEPTH_LOG2;
    localparam logic [33:0]  WIN_BYTES = 34'd4 << DEPTH_LOG2;
    localparam logic [7:0]   LAT_M1    = 8'(READ_LATENCY - 1);
    localparam logic [AW-1:0] ONE_W    = 1;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RD_WAIT = 3'd1;
    localparam logic [2:0] RD_DATA = 3'd2;
    localparam logic [2:0] RD_END  = 3'd3;
    localparam logic [2:0] WR_DATA = 3'd4;
    localparam logic [2:0] ERROR   = 3'd5;

    logic [2:0]    state;
    logic [AW-1:0] word;
    logic [7:0]    beats_left;
    logic [7:0]    lat_cnt;
    logic          wr_done;
    logic          valid_q, end_q, busy_q, err_q;
    logic [31:0]   rd_dat;
    logic [31:0]   mem [0:(2**AW)-1];

    // Request decode; offsets carried in 34 bits so window end never wraps.
    logic [33:0] req_off, last_off;
    logic        claimed, fault;
    assign req_off  = {2'b00, bus.busIn_address_data} - {2'b00, BASE_ADDRESS};
    assign last_off = req_off + {24'd0, bus.busIn_burst_size, 2'b00};
    assign claimed  = bus.busIn_begin_transaction &&
                      (bus.busIn_address_data >= BASE_ADDRESS) && (req_off < WIN_BYTES);
    assign fault    = (bus.busIn_address_data[1:0] != 2'b00) || (last_off >= WIN_BYTES);

    // Single RAM port: the read that feeds the next beat, or one write beat.
    logic          rd_first, rd_next, ram_rd, ram_wr;
    logic [AW-1:0] ram_rd_addr;
    assign rd_first    = (state == RD_WAIT) && (lat_cnt == LAT_M1) && !bus.busIn_end_transaction;
    assign rd_next     = (state == RD_DATA) && !bus.busIn_busy && (beats_left != 8'd0) &&
                         !bus.busIn_end_transaction;
    assign ram_rd      = rd_first || rd_next;
    assign ram_rd_addr = rd_first ? word : word + ONE_W;
    assign ram_wr      = (state == WR_DATA) && bus.busIn_data_valid && !wr_done;

    always_ff @(posedge clock) begin
        if (ram_wr)
            mem[word] <= bus.busIn_address_data;
        else if (ram_rd)
            rd_dat <= mem[ram_rd_addr];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            word       <= '0;
            beats_left <= 8'd0;
            lat_cnt    <= 8'd0;
            wr_done    <= 1'b0;
            valid_q    <= 1'b0;
            end_q      <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            end_q  <= 1'b0;
            err_q  <= 1'b0;
            busy_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (claimed) begin
                        word       <= req_off[AW+1:2];
                        beats_left <= bus.busIn_burst_size;
                        lat_cnt    <= 8'd0;
                        wr_done    <= 1'b0;
                        if (fault) begin
                            state <= ERROR;
                            end_q <= 1'b1;
                            err_q <= 1'b1;
                        end else if (bus.busIn_read_n_write) begin
                            state <= RD_WAIT;
                        end else begin
                            state <= WR_DATA;
                        end
                    end
                end
                RD_WAIT: begin
                    if (bus.busIn_end_transaction) begin
                        state <= IDLE;
                    end else if (lat_cnt == LAT_M1) begin
                        state   <= RD_DATA;
                        valid_q <= 1'b1;
                    end else begin
                        lat_cnt <= lat_cnt + 8'd1;
                    end
                end
                RD_DATA: begin
                    // Abort wins over a same-cycle consume: master gives up, no end pulse.
                    if (bus.busIn_end_transaction) begin
                        state   <= IDLE;
                        valid_q <= 1'b0;
                    end else if (!bus.busIn_busy) begin
                        if (beats_left == 8'd0) begin
                            state   <= RD_END;
                            valid_q <= 1'b0;
                            end_q   <= 1'b1;
                        end else begin
                            word       <= word + ONE_W;
                            beats_left <= beats_left - 8'd1;
                        end
                    end
                end
                RD_END: state <= IDLE;
                WR_DATA: begin
                    if (bus.busIn_data_valid) begin
                        if (ram_wr) begin
                            word <= word + ONE_W;
                            if (beats_left == 8'd0) begin
                                wr_done <= 1'b1;
                                busy_q  <= 1'b1;
                            end else begin
                                beats_left <= beats_left - 8'd1;
                            end
                        end else begin
                            // Beat beyond the announced burst length: dropped, flagged.
                            err_q <= 1'b1;
                        end
                    end
                    if (bus.busIn_end_transaction)
                        state <= IDLE;
                end
                ERROR:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busOut_address_data    = valid_q ? rd_dat : 32'd0;
    assign bus.busOut_data_valid      = valid_q;
    assign bus.busOut_end_transaction = end_q;
    assign bus.busOut_busy            = busy_q;
    assign bus.busOut_error           = err_q;
endmodule

// File: tb/tb_bus_burst_responder.sv
// Directed bench for bus_burst_responder: window 0x1000..0x10FF (64 words), read latency 2.
// Inputs are driven and outputs sampled on the falling clock edge.
// Output flag word used in checks: {valid, end, busy, error} in bits 3..0.
module tb_bus_burst_responder;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   vec_cnt  = 0;
    int   miss_cnt = 0;

    always #5 clock = ~clock;

    bus_burst_responder_if bus_if ();

    bus_burst_responder #(
        .BASE_ADDRESS (32'h0000_1000),
        .DEPTH_LOG2   (6),
        .READ_LATENCY (2)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {28'd0, bus_if.busOut_data_valid, bus_if.busOut_end_transaction,
                bus_if.busOut_busy, bus_if.busOut_error};
    endfunction

    // Presents a begin for one cycle; returns in the cycle right after the sampling edge.
    task automatic drive_begin(input logic [31:0] addr, input logic [7:0] bs, input logic rnw);
        bus_if.busIn_begin_transaction = 1'b1;
        bus_if.busIn_address_data      = addr;
        bus_if.busIn_burst_size        = bs;
        bus_if.busIn_read_n_write      = rnw;
        @(negedge clock);
        bus_if.busIn_begin_transaction = 1'b0;
        bus_if.busIn_address_data      = 32'd0;
        bus_if.busIn_burst_size        = 8'd0;
        bus_if.busIn_read_n_write      = 1'b0;
    endtask

    // Read burst expecting consecutive values from first_val. Beats stall_a/stall_b
    // are held off for 2 cycles; abort_after!=0 ends the transfer on that beat.
    task automatic do_read(input string tag, input logic [31:0] addr, input logic [7:0] bs,
                           input logic [31:0] first_val, input int stall_a, input int stall_b,
                           input int abort_after);
        int beat, hold, vcyc, cyc, nbeats, exp_v;
        bit stop;
        nbeats = int'(bs) + 1;
        drive_begin(addr, bs, 1'b1);
        check({tag, " wait0"}, outs(), 32'h0);
        @(negedge clock);
        check({tag, " wait1"}, outs(), 32'h0);
        @(negedge clock);
        check({tag, " first valid"}, outs(), 32'h8);
        beat = 1; hold = 0; vcyc = 0; cyc = 0; stop = 1'b0;
        while (!stop && cyc < 1000) begin
            if (bus_if.busOut_data_valid) begin
                vcyc++;
                check({tag, " data"}, bus_if.busOut_address_data, first_val + 32'(beat - 1));
                if ((beat == stall_a || beat == stall_b) && hold < 2) begin
                    bus_if.busIn_busy = 1'b1;
                    hold++;
                end else begin
                    bus_if.busIn_busy = 1'b0;
                    hold = 0;
                    if (beat == abort_after) begin
                        bus_if.busIn_end_transaction = 1'b1;
                        stop = 1'b1;
                    end
                    if (beat == nbeats) stop = 1'b1;
                    beat++;
                end
            end
            @(negedge clock);
            cyc++;
            bus_if.busIn_busy            = 1'b0;
            bus_if.busIn_end_transaction = 1'b0;
        end
        exp_v = (abort_after != 0) ? abort_after
              : nbeats + ((stall_a != 0) ? 2 : 0) + ((stall_b != 0) ? 2 : 0);
        check({tag, " valid cycles"}, 32'(vcyc), 32'(exp_v));
        if (abort_after != 0)
            check({tag, " abort outs"}, outs(), 32'h0);
        else
            check({tag, " end pulse"}, outs(), 32'h4);
        check({tag, " data idle"}, bus_if.busOut_address_data, 32'd0);
        @(negedge clock);
        check({tag, " after"}, outs(), 32'h0);
    endtask

    // Write burst of consecutive values; optional single gap cycle after beat gap_after.
    task automatic do_write(input string tag, input logic [31:0] addr, input logic [7:0] bs,
                            input logic [31:0] first_val, input int gap_after,
                            input bit end_with_last);
        int n;
        n = int'(bs) + 1;
        drive_begin(addr, bs, 1'b0);
        for (int i = 1; i <= n; i++) begin
            check({tag, " accepting"}, outs(), 32'h0);
            bus_if.busIn_data_valid   = 1'b1;
            bus_if.busIn_address_data = first_val + 32'(i - 1);
            if (i == n && end_with_last) bus_if.busIn_end_transaction = 1'b1;
            @(negedge clock);
            bus_if.busIn_data_valid      = 1'b0;
            bus_if.busIn_address_data    = 32'd0;
            bus_if.busIn_end_transaction = 1'b0;
            if (i == gap_after) @(negedge clock);
        end
        check({tag, " full busy"}, outs(), 32'h2);
        if (!end_with_last) bus_if.busIn_end_transaction = 1'b1;
        @(negedge clock);
        bus_if.busIn_end_transaction = 1'b0;
        check({tag, " idle"}, outs(), 32'h0);
    endtask

    // Single-cycle request that should fault (exp=5) or be ignored (exp=0).
    task automatic probe(input string tag, input logic [31:0] addr, input logic [7:0] bs,
                         input logic rnw, input logic [31:0] exp);
        drive_begin(addr, bs, rnw);
        check({tag, " pulse"}, outs(), exp);
        check({tag, " data"}, bus_if.busOut_address_data, 32'd0);
        @(negedge clock);
        check({tag, " after"}, outs(), 32'h0);
    endtask

    initial begin
        bus_if.busIn_begin_transaction = 1'b0;
        bus_if.busIn_address_data      = 32'd0;
        bus_if.busIn_burst_size        = 8'd0;
        bus_if.busIn_read_n_write      = 1'b0;
        bus_if.busIn_data_valid        = 1'b0;
        bus_if.busIn_end_transaction   = 1'b0;
        bus_if.busIn_busy              = 1'b0;
        repeat (3) @(negedge clock);
        check("reset outs", outs(), 32'h0);
        reset = 1'b0;
        @(negedge clock);
        check("post reset outs", outs(), 32'h0);
        check("post reset data", bus_if.busOut_address_data, 32'd0);

        // Preload words 0..7 = 1..8, ending on the last beat.
        do_write("preload", 32'h0000_1000, 8'd7, 32'd1, 0, 1'b1);
        do_read("rd8", 32'h0000_1000, 8'd7, 32'd1, 0, 0, 0);
        do_read("rd stall", 32'h0000_1000, 8'd7, 32'd1, 2, 5, 0);

        // Words 16..19, one gap cycle, end after the busy cycle.
        do_write("wr4", 32'h0000_1040, 8'd3, 32'hA5A5_0010, 2, 1'b0);
        do_read("rb4", 32'h0000_1040, 8'd3, 32'hA5A5_0010, 0, 0, 0);
        do_read("rb single", 32'h0000_104C, 8'd0, 32'hA5A5_0013, 0, 0, 0);

        // Window edges and faults.
        do_write("last word wr", 32'h0000_10FC, 8'd0, 32'h1234_5678, 0, 1'b1);
        do_read("last word rd", 32'h0000_10FC, 8'd0, 32'h1234_5678, 0, 0, 0);
        probe("misaligned", 32'h0000_1002, 8'd0, 1'b1, 32'h5);
        probe("past end rd", 32'h0000_10FC, 8'd1, 1'b1, 32'h5);
        probe("past end wr", 32'h0000_10F0, 8'd4, 1'b0, 32'h5);
        probe("below base", 32'h0000_0FFC, 8'd0, 1'b1, 32'h0);
        probe("above top", 32'h0000_1100, 8'd0, 1'b1, 32'h0);

        // Abort after beat 2, then an ordinary read proves the FSM is idle again.
        do_read("abort", 32'h0000_1000, 8'd7, 32'd1, 0, 0, 2);
        do_read("after abort", 32'h0000_1004, 8'd2, 32'd2, 0, 0, 0);

        // Extra write beat beyond a one-beat burst is dropped and flagged.
        drive_begin(32'h0000_1080, 8'd0, 1'b0);
        bus_if.busIn_data_valid   = 1'b1;
        bus_if.busIn_address_data = 32'hBEEF_0001;
        @(negedge clock);
        check("extra busy", outs(), 32'h2);
        bus_if.busIn_address_data = 32'hDEAD_0002;
        @(negedge clock);
        bus_if.busIn_data_valid   = 1'b0;
        bus_if.busIn_address_data = 32'd0;
        check("extra err", outs(), 32'h1);
        bus_if.busIn_end_transaction = 1'b1;
        @(negedge clock);
        bus_if.busIn_end_transaction = 1'b0;
        check("extra idle", outs(), 32'h0);
        do_read("extra rb", 32'h0000_1080, 8'd0, 32'hBEEF_0001, 0, 0, 0);

        // Reset while beat 3 of 8 is on the bus; memory must survive.
        drive_begin(32'h0000_1000, 8'd7, 1'b1);
        repeat (4) @(negedge clock);
        check("mid burst beat3", bus_if.busOut_address_data, 32'd3);
        reset = 1'b1;
        @(negedge clock);
        check("mid reset outs", outs(), 32'h0);
        check("mid reset data", bus_if.busOut_address_data, 32'd0);
        reset = 1'b0;
        @(negedge clock);
        do_read("post mid reset", 32'h0000_1000, 8'd7, 32'd1, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end
endmodule
